// File: rtl/highlight.sv
// highlight: pops mask/pixel pairs, writes the pixel or a highlight colour, counts motion per frame.
// Per-frame statistics (acc, motion_count, motion_flag, frame_done) are built only when HIGHLIGHT_STATS_EN is defined.
module highlight #(
    parameter int unsigned   WIDTH         = 720,
    parameter int unsigned   HEIGHT        = 540,
    parameter logic [23:0]   HIGHLIGHT     = 24'hFF0000,
    parameter int unsigned   MOTION_THRESH = 1000,
    localparam int unsigned  CW            = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic           clock,
    input  logic           reset,
    output logic           mask_rd_en,
    input  logic           mask_empty,
    input  logic           mask_dout,
    output logic           pix_rd_en,
    input  logic           pix_empty,
    input  logic [23:0]    pix_dout,
    output logic           out_wr_en,
    input  logic           out_full,
    output logic [23:0]    out_din,
    output logic           frame_done,
    output logic [CW-1:0]  motion_count,
    output logic           motion_flag
);

    localparam int unsigned   NPIX     = WIDTH * HEIGHT;
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    typedef enum logic {S_READ = 1'b0, S_WRITE = 1'b1} state_t;

    state_t         r_state;
    logic [23:0]    r_pixel;
    logic [CW-1:0]  r_pix_cnt;
    logic           w_pop;
    logic           w_write;

    // Strobes are gated by reset so neither FIFO is touched while reset is held.
    assign w_pop      = (r_state == S_READ) && !mask_empty && !pix_empty && !reset;
    assign w_write    = (r_state == S_WRITE) && !out_full && !reset;
    assign mask_rd_en = w_pop;
    assign pix_rd_en  = w_pop;
    assign out_wr_en  = w_write;
    assign out_din    = w_write ? r_pixel : 24'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_READ;
            r_pixel   <= 24'h0;
            r_pix_cnt <= '0;
        end else begin
            case (r_state)
                S_READ: begin
                    if (w_pop) begin
                        r_pixel <= mask_dout ? pix_dout : HIGHLIGHT;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_write) begin
                        r_state   <= S_READ;
                        r_pix_cnt <= (r_pix_cnt == LAST_PIX) ? '0 : r_pix_cnt + CW'(1);
                    end
                end
                default: r_state <= S_READ;
            endcase
        end
    end

`ifdef HIGHLIGHT_STATS_EN
    logic           r_is_motion;
    logic [CW-1:0]  r_acc;
    logic [CW-1:0]  r_motion_count;
    logic           r_motion_flag;
    logic           r_frame_done;
    logic           w_last;
    logic [CW-1:0]  w_total;

    // Frame total includes the closing pixel, which has not yet reached the accumulator.
    assign w_last  = w_write && (r_pix_cnt == LAST_PIX);
    assign w_total = r_acc + CW'(r_is_motion);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_motion    <= 1'b0;
            r_acc          <= '0;
            r_motion_count <= '0;
            r_motion_flag  <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_pop) begin
                r_is_motion <= ~mask_dout;
            end
            if (w_last) begin
                r_motion_count <= w_total;
                r_motion_flag  <= (32'(w_total) >= MOTION_THRESH);
                r_acc          <= '0;
            end else if (w_write && r_is_motion) begin
                r_acc <= r_acc + CW'(1);
            end
        end
    end

    assign motion_count = r_motion_count;
    assign motion_flag  = r_motion_flag;
    assign frame_done   = r_frame_done;
`else
    assign motion_count = '0;
    assign motion_flag  = 1'b0;
    assign frame_done   = 1'b0;
`endif

endmodule

// File: doc/highlight.md
# highlight

Downstream neighbour of the subtract stage in the motion-detect pipeline. Each cycle pair, it pops one 1-bit motion-mask value from the subtract stage's output FIFO and the matching 24-bit RGB pixel from the original-frame FIFO. It writes the pixel to the output FIFO, replacing it with a highlight colour where the mask reports motion. It also counts motion pixels per frame and reports a per-frame summary.

## Interface
Parameters:
- WIDTH, 720: pixels per line.
- HEIGHT, 540: lines per frame.
- HIGHLIGHT, 24'hFF0000: RGB value substituted for motion pixels.
- MOTION_THRESH, 1000: minimum motion-pixel count per frame that sets motion_flag.

Ports:
- clock  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mask_rd_en  out  1  pop strobe for the mask FIFO.
- mask_empty  in  1  mask FIFO empty.
- mask_dout  in  1  mask bit: 1 = static (|diff| ≤ 0x32), 0 = motion.
- pix_rd_en  out  1  pop strobe for the RGB FIFO.
- pix_empty  in  1  RGB FIFO empty.
- pix_dout  in  24  RGB pixel, {R,G,B}.
- out_wr_en  out  1  push strobe to the output FIFO.
- out_full  in  1  output FIFO full.
- out_din  out  24  output pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- motion_count  out  CW  motion pixels in the last completed frame; CW = $clog2(WIDTH*HEIGHT+1).
- motion_flag  out  1  motion_count ≥ MOTION_THRESH for the last completed frame.

## Operation
- Two-state FSM:
  - S_READ (reset state): when mask_empty==0 AND pix_empty==0, assert mask_rd_en and pix_rd_en in the same cycle, then go to S_WRITE.
  - Registered on that same edge: pixel_r = mask_dout ? pix_dout : HIGHLIGHT; is_motion_r = ~mask_dout.
  - If either FIFO is empty, neither is popped. The two FIFOs are never popped independently.
  - S_WRITE: when out_full==0, assert out_wr_en with out_din = pixel_r, then go to S_READ. Otherwise hold state and registers.
- out_din = 0 whenever out_wr_en = 0.
- Pixel counter pix_cnt (CW bits) increments on each write.
  - On the write with pix_cnt == WIDTH*HEIGHT-1, it wraps to 0 and the frame closes.
- Motion accumulator acc increments on each write where is_motion_r = 1.
- On frame close:
  - motion_count <= acc + is_motion_r, so the last pixel is counted.
  - motion_flag <= (acc + is_motion_r) ≥ MOTION_THRESH.
  - acc <= 0.
  - frame_done pulses high for exactly the next cycle.
- motion_count and motion_flag hold their values until the next frame close.
- Arithmetic is unsigned. acc cannot overflow, because CW covers WIDTH*HEIGHT.

## Timing
- Reset values:
  - state = S_READ.
  - mask_rd_en, pix_rd_en, out_wr_en = 0.
  - out_din = 0.
  - frame_done = 0, motion_count = 0, motion_flag = 0.
  - pixel_r, is_motion_r, pix_cnt, acc = 0.
- Latency: pop in cycle N; the earliest out_wr_en is in cycle N+1.
  - Throughput is at most one pixel per 2 cycles.
- Read strobes are combinational from state and the empty flags. out_wr_en is combinational from state and out_full.
- out_full held high stalls in S_WRITE indefinitely. No pops occur while stalled.
- frame_done is registered: it is high in cycle M+1 for a last-pixel write in cycle M.
- Reset mid-frame or mid-stall: state, counters and outputs clear immediately. A popped but unwritten pixel is discarded, and the next frame starts at pix_cnt = 0.

## Configuration
- HIGHLIGHT_STATS_EN:
  - Defined: acc, motion_count, motion_flag and frame_done behave as specified.
  - Undefined: the accumulator and threshold compare are compiled out, and motion_count, motion_flag and frame_done are tied to 0.
  - The pixel path and pix_cnt are identical in both builds.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2, MOTION_THRESH=3.
- Reset:
  - Assert reset mid-S_WRITE -> all outputs 0 in the same cycle; state S_READ after release.
- Pass-through:
  - 8 pixels 0x123456 with mask=1 -> 8 writes of 0x123456.
  - frame_done pulses once; motion_count=0, motion_flag=0.
- Highlight and count:
  - masks 0,1,0,1,1,1,1,0 with pixels 0x0A0B0C -> outputs FF0000, 0A0B0C, FF0000, 0A0B0C ×4, FF0000.
  - motion_count=3, motion_flag=1; the last pixel is counted.
- Backpressure:
  - out_full=1 for 5 cycles after a pop -> out_wr_en=0, no further pops.
  - On release, the held pixel is written once, unaltered.
- Empty handling:
  - pix_empty=0, mask_empty=1 -> no rd_en asserted on either FIFO.
  - Clearing mask_empty -> both popped in the same cycle.
- Config off:
  - Build without HIGHLIGHT_STATS_EN and repeat the highlight scenario -> same out_din stream; frame_done, motion_count, motion_flag stay 0.
